// File: rtl/sram_bridge_32_if.sv
// CPU-side request/response bundle for the 32-bit to 16-bit SRAM bridge.
// Latency: none (wiring only).
// Backpressure: the CPU holds cs until the one-cycle ready pulse; there is no other stall signal.
interface sram_bridge_32_if;
  logic        cs;       // request for external SRAM
  logic        rnw;      // 1 = read, 0 = write
  logic [19:0] address;  // CPU word address
  logic [31:0] din;      // CPU write data
  logic [31:0] dout;     // read data back to the CPU mux
  logic        ready;    // one-cycle completion pulse

  // CPU side drives the request and receives the response.
  modport master (
    output cs, rnw, address, din,
    input  dout, ready
  );

  // Bridge side accepts the request and returns the response.
  modport slave (
    input  cs, rnw, address, din,
    output dout, ready
  );
endinterface

// File: rtl/sram_bridge_32.sv
// Splits 32-bit CPU accesses into two 16-bit async SRAM cycles, low half first, then high half.
// Latency: ready pulses 2*WAIT_STATES+5 cycles after cs is accepted (1 cycle for writes with SRAM_WRITE_POST_EN).
// Backpressure: requests are accepted only in IDLE; cs is ignored while a transfer is in flight.
// Optional build macro SRAM_WRITE_POST_EN posts writes: ready right after acceptance, SRAM cycles run behind it.
module sram_bridge_32 #(
  parameter int ADDR_WIDTH  = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_bridge_32_if.slave       cpu,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic                  ram_cs_b,
  output logic                  ram_oe_b,
  output logic                  ram_we_b,
  output logic [15:0]           ram_wdata,
  output logic                  ram_wdata_en,
  input  logic [15:0]           ram_rdata
);

  // Half-word index width inside the SRAM and the strobe counter width.
  localparam int IW = ADDR_WIDTH - 1;
  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_STATES);

  typedef enum logic [2:0] {
    IDLE,
    LO_SETUP,
    LO_STROBE,
    HI_SETUP,
    HI_STROBE,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt, cnt_nxt;

  // Request captured in IDLE; the low data half goes straight to the pads at acceptance,
  // so only the high half needs to be kept.
  logic          req_rnw;
  logic [IW-1:0] req_idx;
  logic [15:0]   req_din_hi;
  logic          req_latch;

  // Next values of the registered outputs.
  logic [ADDR_WIDTH-1:0] adr_nxt;
  logic                  cs_b_nxt;
  logic                  oe_b_nxt;
  logic                  we_b_nxt;
  logic [15:0]           wdata_nxt;
  logic                  wdata_en_nxt;
  logic [31:0]           dout_nxt;
  logic                  ready_nxt;

  logic last_strobe;

  // Address bits above the SRAM word index are deliberately dropped (index wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu.address[19:IW];

  assign last_strobe = (cnt == LAST_CNT);

  // Next-state and next-output decode; every pad output is registered from these values,
  // so each state's pad levels appear in the same cycle as the state itself.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    req_latch    = 1'b0;
    adr_nxt      = ram_adr;
    cs_b_nxt     = 1'b1;
    oe_b_nxt     = 1'b1;
    we_b_nxt     = 1'b1;
    wdata_nxt    = ram_wdata;
    wdata_en_nxt = 1'b0;
    dout_nxt     = cpu.dout;
    ready_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (cpu.cs) begin
          req_latch = 1'b1;
          state_nxt = LO_SETUP;
          adr_nxt   = {cpu.address[IW-1:0], 1'b0};
          cs_b_nxt  = 1'b0;
          if (cpu.rnw) begin
            oe_b_nxt = 1'b0;
          end else begin
            wdata_nxt    = cpu.din[15:0];
            wdata_en_nxt = 1'b1;
`ifdef SRAM_WRITE_POST_EN
            ready_nxt    = 1'b1;
`endif
          end
        end
      end

      LO_SETUP, HI_SETUP: begin
        // Enter the strobe: reads keep OE low, writes pull WE low with data still driven.
        state_nxt = (state == LO_SETUP) ? LO_STROBE : HI_STROBE;
        cnt_nxt   = '0;
        cs_b_nxt  = 1'b0;
        if (req_rnw) begin
          oe_b_nxt = 1'b0;
        end else begin
          we_b_nxt     = 1'b0;
          wdata_en_nxt = 1'b1;
        end
      end

      LO_STROBE: begin
        cs_b_nxt = 1'b0;
        if (last_strobe) begin
          // WE rises here while the data is still driven; next cycle sets up the high half.
          state_nxt = HI_SETUP;
          adr_nxt   = {req_idx, 1'b1};
          if (req_rnw) begin
            dout_nxt[15:0] = ram_rdata;
            oe_b_nxt       = 1'b0;
          end else begin
            wdata_nxt    = req_din_hi;
            wdata_en_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (req_rnw) begin
            oe_b_nxt = 1'b0;
          end else begin
            we_b_nxt     = 1'b0;
            wdata_en_nxt = 1'b1;
          end
        end
      end

      HI_STROBE: begin
        if (last_strobe) begin
          // Release the SRAM and report completion in DONE.
          state_nxt = DONE;
          if (req_rnw) begin
            dout_nxt[31:16] = ram_rdata;
          end
`ifdef SRAM_WRITE_POST_EN
          ready_nxt = req_rnw;
`else
          ready_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt  = cnt + CW'(1);
          cs_b_nxt = 1'b0;
          if (req_rnw) begin
            oe_b_nxt = 1'b0;
          end else begin
            we_b_nxt     = 1'b0;
            wdata_en_nxt = 1'b1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_rnw    <= 1'b0;
      req_idx    <= '0;
      req_din_hi <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (req_latch) begin
        req_rnw    <= cpu.rnw;
        req_idx    <= cpu.address[IW-1:0];
        req_din_hi <= cpu.din[31:16];
      end
    end
  end

  // Registered pad and CPU-facing outputs; reset abandons any partial access silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_adr      <= '0;
      ram_cs_b     <= 1'b1;
      ram_oe_b     <= 1'b1;
      ram_we_b     <= 1'b1;
      ram_wdata    <= '0;
      ram_wdata_en <= 1'b0;
      cpu.dout     <= '0;
      cpu.ready    <= 1'b0;
    end else begin
      ram_adr      <= adr_nxt;
      ram_cs_b     <= cs_b_nxt;
      ram_oe_b     <= oe_b_nxt;
      ram_we_b     <= we_b_nxt;
      ram_wdata    <= wdata_nxt;
      ram_wdata_en <= wdata_en_nxt;
      cpu.dout     <= dout_nxt;
      cpu.ready    <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_sram_bridge_32.sv
// Bench for sram_bridge_32: one instance at WAIT_STATES=1, one at WAIT_STATES=0, each on its own SRAM model.
// Directed steps followed by randomized accesses against a word-level memory model.
module tb_sram_bridge_32;

`ifdef SRAM_WRITE_POST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  int          sel;
  logic        cs_drv, rnw_drv;
  logic [19:0] addr_drv;
  logic [31:0] din_drv;

  int n_tests = 0;
  int n_fail  = 0;

  sram_bridge_32_if bus0();
  sram_bridge_32_if bus1();

  assign bus0.cs      = (sel == 0) && cs_drv;
  assign bus0.rnw     = rnw_drv;
  assign bus0.address = addr_drv;
  assign bus0.din     = din_drv;
  assign bus1.cs      = (sel == 1) && cs_drv;
  assign bus1.rnw     = rnw_drv;
  assign bus1.address = addr_drv;
  assign bus1.din     = din_drv;

  logic [17:0] adr0, adr1;
  logic        cs_b0, oe_b0, we_b0, en0, cs_b1, oe_b1, we_b1, en1;
  logic [15:0] wd0, wd1, rd0, rd1;

  sram_bridge_32 #(.ADDR_WIDTH(18), .WAIT_STATES(1)) dut0 (
    .clk(clk), .reset(reset), .cpu(bus0),
    .ram_adr(adr0), .ram_cs_b(cs_b0), .ram_oe_b(oe_b0), .ram_we_b(we_b0),
    .ram_wdata(wd0), .ram_wdata_en(en0), .ram_rdata(rd0)
  );

  sram_bridge_32 #(.ADDR_WIDTH(18), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .cpu(bus1),
    .ram_adr(adr1), .ram_cs_b(cs_b1), .ram_oe_b(oe_b1), .ram_we_b(we_b1),
    .ram_wdata(wd1), .ram_wdata_en(en1), .ram_rdata(rd1)
  );

  // Async SRAM models: a half-word is stored whenever CS and WE are both low at a clock edge.
  logic [15:0] mem0 [0:(1<<18)-1];
  logic [15:0] mem1 [0:(1<<18)-1];
  always @(posedge clk) if (!cs_b0 && !we_b0) mem0[adr0] <= wd0;
  always @(posedge clk) if (!cs_b1 && !we_b1) mem1[adr1] <= wd1;
  assign rd0 = oe_b0 ? 16'h5A5A : mem0[adr0];
  assign rd1 = oe_b1 ? 16'h5A5A : mem1[adr1];

  // View of the currently selected instance.
  logic [31:0] v_dout;
  logic        v_ready, v_cs_b, v_oe_b, v_we_b, v_en;
  logic [17:0] v_adr;
  logic [15:0] v_wd;
  always_comb begin
    v_dout  = (sel == 1) ? bus1.dout  : bus0.dout;
    v_ready = (sel == 1) ? bus1.ready : bus0.ready;
    v_adr   = (sel == 1) ? adr1  : adr0;
    v_cs_b  = (sel == 1) ? cs_b1 : cs_b0;
    v_oe_b  = (sel == 1) ? oe_b1 : oe_b0;
    v_we_b  = (sel == 1) ? we_b1 : we_b0;
    v_wd    = (sel == 1) ? wd1   : wd0;
    v_en    = (sel == 1) ? en1   : en0;
  end

  // Reference model: 32-bit words keyed by instance and word index, plus last read word per instance.
  logic [31:0] exp_mem [int];
  logic [31:0] last_dout [2];

  function automatic int key_of(int s, logic [19:0] a);
    return s * 32'h20000 + int'(a[16:0]);
  endfunction

  function automatic logic [15:0] memrd(int s, logic [17:0] a);
    return (s == 1) ? mem1[a] : mem0[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One 32-bit access. Called at a negedge; pre=1 means the call happens in the DONE cycle
  // of the previous access with cs held, so acceptance happens one IDLE cycle later.
  task automatic access(input int s, input bit rnw, input logic [19:0] a,
                        input logic [31:0] d, input bit pre);
    int          w, n_cyc, exp_lat, rdy_cnt, rdy_cyc, lo_we, hi_we;
    bit          overlap, en_seen;
    logic [17:0] lo_adr, hi_adr, base;
    logic [15:0] lo_wd, hi_wd;
    logic [31:0] got;
    w       = (s == 1) ? 0 : 1;
    n_cyc   = 2 * w + 5;
    exp_lat = (POSTED && !rnw) ? 1 : n_cyc;
    rdy_cnt = 0; rdy_cyc = -1; lo_we = 0; hi_we = 0;
    overlap = 0; en_seen = 0; lo_adr = '1; hi_adr = '1; lo_wd = '0; hi_wd = '0; got = '0;
    base    = {a[16:0], 1'b0};
    sel = s; cs_drv = 1'b1; rnw_drv = rnw; addr_drv = a; din_drv = d;
    if (pre) begin
      @(negedge clk);
      chk("gap_cs_b", 32'(v_cs_b), 32'd1);
      chk("gap_ready", 32'(v_ready), 32'd0);
    end
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      if (v_ready) begin rdy_cnt++; rdy_cyc = c; got = v_dout; end
      if (!v_oe_b && v_en) overlap = 1;
      if (v_en) en_seen = 1;
      if (c == 1) lo_adr = v_adr;
      if (c == w + 3) hi_adr = v_adr;
      if (!v_we_b) begin
        if (v_adr[0]) begin hi_we++; hi_wd = v_wd; end
        else begin lo_we++; lo_wd = v_wd; end
      end
      if (c == 1) begin
        cs_drv = 1'b0; rnw_drv = 1'($urandom); addr_drv = 20'($urandom); din_drv = $urandom;
      end
    end
    chk("ready_count", 32'(rdy_cnt), 32'd1);
    chk("ready_cycle", 32'(rdy_cyc), 32'(exp_lat));
    chk("lo_adr", 32'(lo_adr), 32'(base));
    chk("hi_adr", 32'(hi_adr), 32'(base | 18'd1));
    chk("oe_en_overlap", 32'(overlap), 32'd0);
    if (rnw) begin
      chk("read_dout", got, exp_mem[key_of(s, a)]);
      chk("read_no_wdata_en", 32'(en_seen), 32'd0);
      chk("read_no_we", 32'(lo_we + hi_we), 32'd0);
      last_dout[s] = exp_mem[key_of(s, a)];
    end else begin
      chk("lo_we_cycles", 32'(lo_we), 32'(w + 1));
      chk("hi_we_cycles", 32'(hi_we), 32'(w + 1));
      chk("lo_wdata", 32'(lo_wd), 32'(d[15:0]));
      chk("hi_wdata", 32'(hi_wd), 32'(d[31:16]));
      chk("sram_lo", 32'(memrd(s, base)), 32'(d[15:0]));
      chk("sram_hi", 32'(memrd(s, base | 18'd1)), 32'(d[31:16]));
      chk("write_keeps_dout", v_dout, last_dout[s]);
      exp_mem[key_of(s, a)] = d;
    end
  endtask

  logic [16:0] pool [6];

  initial begin
    bit seen_rdy, cs_low;
    logic [31:0] d;
    logic [19:0] a;
    bit rnw, pre;

    reset = 1'b1; sel = 0; cs_drv = 1'b0; rnw_drv = 1'b0; addr_drv = '0; din_drv = '0;
    last_dout[0] = '0; last_dout[1] = '0;

    // Reset held three cycles: all outputs at reset values on both instances.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk("rst_dout", v_dout, 32'd0);
      chk("rst_ready", 32'(v_ready), 32'd0);
      chk("rst_adr", 32'(v_adr), 32'd0);
      chk("rst_cs_b", 32'(v_cs_b), 32'd1);
      chk("rst_oe_b", 32'(v_oe_b), 32'd1);
      chk("rst_we_b", 32'(v_we_b), 32'd1);
      chk("rst_wdata", 32'(v_wd), 32'd0);
      chk("rst_wdata_en", 32'(v_en), 32'd0);
    end
    sel = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk("idle_cs_b", 32'(v_cs_b), 32'd1);
      chk("idle_ready", 32'(v_ready), 32'd0);
    end

    // Directed write then read at word 0x00010.
    @(negedge clk);
    access(0, 1'b0, 20'h00010, 32'hDEADBEEF, 1'b0);
    repeat (2) @(negedge clk);
    access(0, 1'b1, 20'h00010, 32'h0, 1'b0);
    chk("dout_after_read", bus0.dout, 32'hDEADBEEF);

    // Zero wait states, back-to-back write then read at the top of the index range.
    @(negedge clk);
    d = $urandom;
    access(1, 1'b0, 20'h3FFFF, d, 1'b0);
    access(1, 1'b1, 20'h3FFFF, 32'h0, 1'b1);

    // Reset during the low-half strobe of a write leaves only the low half written.
    @(negedge clk);
    access(0, 1'b0, 20'h00123, 32'h11112222, 1'b0);
    @(negedge clk);
    sel = 0; cs_drv = 1'b1; rnw_drv = 1'b0; addr_drv = 20'h00123; din_drv = 32'hAAAABBBB;
    @(negedge clk);
    cs_drv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_we_b", 32'(v_we_b), 32'd1);
    chk("midrst_wdata_en", 32'(v_en), 32'd0);
    chk("midrst_cs_b", 32'(v_cs_b), 32'd1);
    chk("midrst_ready", 32'(v_ready), 32'd0);
    reset = 1'b0;
    last_dout[0] = '0; last_dout[1] = '0;
    seen_rdy = 0; cs_low = 0;
    repeat (10) begin
      @(negedge clk);
      if (v_ready) seen_rdy = 1;
      if (!v_cs_b) cs_low = 1;
    end
    chk("midrst_no_ready", 32'(seen_rdy), 32'd0);
    chk("midrst_no_cs", 32'(cs_low), 32'd0);
    chk("partial_lo", 32'(mem0[18'h00246]), 32'h0000BBBB);
    chk("partial_hi", 32'(mem0[18'h00247]), 32'h00001111);
    exp_mem[key_of(0, 20'h00123)] = 32'h1111BBBB;
    access(0, 1'b1, 20'h00123, 32'h0, 1'b0);

    // Write immediately followed by a read of the same word.
    @(negedge clk);
    d = $urandom;
    access(0, 1'b0, 20'h00456, d, 1'b0);
    access(0, 1'b1, 20'h00456, 32'h0, 1'b1);

    // Randomized traffic on both instances; upper address bits are random to exercise wrap.
    for (int i = 0; i < 6; i++) pool[i] = 17'($urandom);
    for (int i = 0; i < 40; i++) begin
      int s;
      s   = int'($urandom_range(0, 1));
      a   = {3'($urandom), pool[$urandom_range(0, 5)]};
      rnw = 1'($urandom);
      if (rnw && !exp_mem.exists(key_of(s, a))) rnw = 1'b0;
      d   = $urandom;
      pre = (s == sel) && (i > 0) && ($urandom_range(0, 1) == 1);
      if (!pre) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      access(s, rnw, a, d, pre);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
